// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the core and the
// iterative RV32M multiply/divide unit.
//   start      core -> unit  request a new operation (sampled only when idle)
//   op         core -> unit  funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU
//                                    4 DIV 5 DIVU 6 REM  7 REMU
//   operand_a  core -> unit  rs1 value
//   operand_b  core -> unit  rs2 value (operand-mux output)
//   busy       unit -> core  operation in progress (stall)
//   done       unit -> core  one-cycle completion pulse
//   result     unit -> core  registered result, held until next completion
interface mul_div_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (output start, op, operand_a, operand_b,
                  input  busy, done, result);
  modport slave  (input  start, op, operand_a, operand_b,
                  output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit RV32M multiply/divide.
// Multiply is shift-add (LSB first), divide is restoring (MSB first); both
// take 32 iterations on operand magnitudes, signs are applied at FINISH.
// Divide-by-zero and signed overflow skip iteration and finish next cycle.
//   clk_i  core clock, rising edge
//   rst_i  asynchronous active-high reset
//   md     slave side of mul_div_unit_if (start/op/operands in,
//          busy/done/result out)
module mul_div_unit (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_div_unit_if.slave  md
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [63:0] a_q;        // multiplicand (shifts left) / dividend (MSB at bit 31)
  logic [31:0] b_q;        // multiplier (shifts right) / divisor
  logic [31:0] rem_q;      // partial remainder, always < divisor
  logic [63:0] acc_q;      // product / quotient; special value when special_q
  logic [5:0]  cnt_q;
  logic        sign_a_q, sign_b_q, special_q;
  logic        done_q;
  logic [31:0] result_q;

  // ---- operand decode at start ----
  logic        signed_a, signed_b, neg_a, neg_b, div0, ovf;
  logic [31:0] mag_a, mag_b, spec_val;

  always_comb begin
    // A is signed for MUL/MULH/MULHSU/DIV/REM; B only for MUL/MULH/DIV/REM.
    // MUL's low word is sign-agnostic, so treating it as signed is harmless.
    signed_a = !(md.op == 3'd3 || md.op == 3'd5 || md.op == 3'd7);
    signed_b = (md.op == 3'd0 || md.op == 3'd1 || md.op == 3'd4 || md.op == 3'd6);
    neg_a    = signed_a & md.operand_a[31];
    neg_b    = signed_b & md.operand_b[31];
    mag_a    = neg_a ? (32'd0 - md.operand_a) : md.operand_a;
    mag_b    = neg_b ? (32'd0 - md.operand_b) : md.operand_b;
    div0     = md.op[2] && (md.operand_b == 32'd0);
    ovf      = (md.op == 3'd4 || md.op == 3'd6) &&
               (md.operand_a == 32'h8000_0000) && (md.operand_b == 32'hFFFF_FFFF);
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (div0) spec_val = md.op[1] ? md.operand_a : 32'hFFFF_FFFF;
    else      spec_val = md.op[1] ? 32'd0 : 32'h8000_0000;
  end

  // ---- one iteration ----
  logic [32:0] trial;
  logic        qbit;
  logic [63:0] mul_acc;

  always_comb begin
    trial   = {rem_q, a_q[31]};
    qbit    = (trial >= {1'b0, b_q});
    mul_acc = acc_q + (b_q[0] ? a_q : 64'd0);
  end

  // ---- sign fix-up and result select ----
  logic [63:0] prod;
  logic [31:0] quo, remv, fin;

  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;
    quo  = (sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    remv = sign_a_q ? (32'd0 - rem_q) : rem_q;
    if (special_q)     fin = acc_q[31:0];
    else if (op_q[2])  fin = op_q[1] ? remv : quo;
    else               fin = (op_q == 3'd0) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      a_q       <= 64'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 6'd0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (md.start) begin
          op_q      <= md.op;
          a_q       <= {32'd0, mag_a};
          b_q       <= mag_b;
          sign_a_q  <= neg_a;
          sign_b_q  <= neg_b;
          rem_q     <= 32'd0;
          cnt_q     <= 6'd0;
          special_q <= div0 | ovf;
          // special cases park their final value in the accumulator
          acc_q     <= (div0 | ovf) ? {32'd0, spec_val} : 64'd0;
          state_q   <= (div0 | ovf) ? FINISH : CALC;
        end
        CALC: begin
          cnt_q <= cnt_q + 6'd1;
          a_q   <= a_q << 1;
          if (op_q[2]) begin
            rem_q <= qbit ? (trial[31:0] - b_q) : trial[31:0];
            acc_q <= {acc_q[62:0], qbit};
          end else begin
            acc_q <= mul_acc;
            b_q   <= b_q >> 1;
          end
          if (cnt_q == 6'd31) state_q <= FINISH;
        end
        FINISH: begin
          result_q <= fin;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.busy   = (state_q != IDLE);
  assign md.done   = done_q;
  assign md.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if bus();
  mul_div_unit dut (.clk_i(clk), .rst_i(rst), .md(bus));

  typedef struct {
    logic [31:0] res;
    int          due;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: RV32M semantics in plain arithmetic ----
  function automatic logic [31:0] ref_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int          sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000;
            else return 32'(sa / sb);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int lat_of(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // ---- driver helpers: all start and end at a negedge ----
  task automatic issue_exp(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    exp_t x;
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    x.res = e; x.lat = lat_of(op, a, b); x.due = cyc + 1 + x.lat;
    sbq.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    issue_exp(op, a, b, ref_op(op, a, b));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin @(negedge clk); n++; end
    if (bus.busy) begin total++; bad++; $display("FAIL wait_idle busy stuck"); end
  endtask

  // ---- monitor / scoreboard ----
  initial begin
    exp_t        e;
    int          busy_cnt = 0;
    logic [31:0] last_res = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin busy_cnt = 0; last_res = 32'd0; continue; end
      if (bus.done) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done act=%h exp=no_done", bus.result);
        end else begin
          e = sbq.pop_front();
          chk("result", bus.result, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        busy_cnt = 0;
        last_res = bus.result;
      end else begin
        chk("result_hold", bus.result, last_res);
        if (bus.busy) busy_cnt++;
      end
    end
  end

  // ---- stimulus ----
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          n;
    bus.start = 1'b0; bus.op = 3'd0; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed arithmetic
    issue_exp(3'd0, 32'd7, 32'd6, 32'd42);                      wait_idle();
    issue_exp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);       wait_idle();
    issue_exp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_idle();
    issue_exp(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);       wait_idle();
    issue_exp(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);       wait_idle();
    issue_exp(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);       wait_idle();
    issue_exp(3'd5, 32'd100, 32'd7, 32'd14);                    wait_idle();
    issue_exp(3'd7, 32'd100, 32'd7, 32'd2);                     wait_idle();
    // special cases
    issue_exp(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);               wait_idle();
    issue_exp(3'd6, 32'd5, 32'd0, 32'd5);                       wait_idle();
    issue_exp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_idle();
    issue_exp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);       wait_idle();
    repeat (2) @(negedge clk);

    // Start during a running DIV must be ignored
    issue_exp(3'd4, 32'd1000, 32'd7, 32'd142);
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.operand_a = 32'd50; bus.operand_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    // Start in the Done cycle is accepted
    n = 0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    issue_exp(3'd0, 32'd5, 32'd5, 32'd25);
    chk("busy_after_done_start", {31'd0, bus.busy}, 32'd1);
    wait_idle();

    // asynchronous reset mid-MUL
    issue(3'd0, 32'd123, 32'd456);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue_exp(3'd0, 32'd3, 32'd3, 32'd9);
    wait_idle();

    // randomized
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(op, a, b);
      wait_idle();
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
